// File: rtl/cam_init_sequencer.sv
// Walks a register table and replays each {reg, val} entry as an SCCB write
// through an external I2C master, with inline delay entries, NACK retries and fault reporting.
module cam_init_sequencer #(
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter int unsigned TBL_AW    = 6,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned DLY_UNIT  = 1024,
  parameter int unsigned SETTLE    = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              i2c_req,
  output logic [7:0]        dev_addr,
  output logic [7:0]        reg_addr,
  output logic [7:0]        wdata,
  input  logic              i2c_done,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] fail_idx
);

  localparam int unsigned DLY_W = 8 + $clog2(DLY_UNIT);
  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam int unsigned CNT_W = (DLY_W > SET_W) ? DLY_W : SET_W;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_SETTLE, S_DELAY, S_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [TBL_AW-1:0]  tbl_addr_q, tbl_addr_d;
  logic [TBL_AW-1:0]  fail_idx_q, fail_idx_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         val_q, val_d;
  logic [7:0]         dev_addr_q, dev_addr_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic is_end_c, is_dly_c, cnt_last_c, addr_last_c, can_retry_c;

  assign is_end_c    = (tbl_data == 16'hFFFF);
  assign is_dly_c    = (tbl_data[15:8] == 8'hF0);
  assign cnt_last_c  = (cnt_q <= CNT_W'(1));
  assign addr_last_c = &tbl_addr_q;
  assign can_retry_c = (retry_q < RTY_W'(MAX_RETRY));

  // State register
  always_ff @(posedge clk) begin
    if (!res) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH: begin
        if (is_end_c)      state_d = S_IDLE;
        else if (is_dly_c) state_d = S_DELAY;
        else               state_d = S_ISSUE;
      end
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          if (!i2c_nack) state_d = addr_last_c ? S_FAIL : S_SETTLE;
          else           state_d = can_retry_c ? S_SETTLE : S_FAIL;
        end
      end
      // A nonzero retry count means the entry just NACKed and is reissued as-is
      S_SETTLE: if (cnt_last_c) state_d = (retry_q != '0) ? S_ISSUE : S_FETCH;
      S_DELAY:  if (cnt_last_c) state_d = addr_last_c ? S_FAIL : S_FETCH;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output register next values
  always_comb begin
    tbl_addr_d = tbl_addr_q;
    fail_idx_d = fail_idx_q;
    reg_d      = reg_q;
    val_d      = val_q;
    dev_addr_d = dev_addr_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tbl_addr_d = '0;
          retry_d    = '0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          dev_addr_d = DEV_ADDR;
        end
      end
      S_LATCH: begin
        reg_d = tbl_data[15:8];
        val_d = tbl_data[7:0];
        if (is_end_c) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (is_dly_c) begin
          cnt_d = CNT_W'(tbl_data[7:0]) * CNT_W'(DLY_UNIT);
        end else begin
          req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i2c_done) begin
          req_d = 1'b0;
          cnt_d = CNT_W'(SETTLE);
          if (!i2c_nack) begin
            retry_d = '0;
            // The last index is kept on wrap so FAIL reports it directly
            if (!addr_last_c) tbl_addr_d = tbl_addr_q + TBL_AW'(1);
          end else if (can_retry_c) begin
            retry_d = retry_q + RTY_W'(1);
          end
        end
      end
      S_SETTLE: begin
        if (cnt_last_c) begin
          if (retry_q != '0) req_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt_last_c) begin
          if (!addr_last_c) tbl_addr_d = tbl_addr_q + TBL_AW'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FAIL: begin
        error_d    = 1'b1;
        fail_idx_d = tbl_addr_q;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!res) begin
      tbl_addr_q <= '0;
      fail_idx_q <= '0;
      reg_q      <= '0;
      val_q      <= '0;
      dev_addr_q <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      tbl_addr_q <= tbl_addr_d;
      fail_idx_q <= fail_idx_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      dev_addr_q <= dev_addr_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign tbl_addr = tbl_addr_q;
  assign fail_idx = fail_idx_q;
  assign i2c_req  = req_q;
  assign dev_addr = dev_addr_q;
  assign reg_addr = reg_q;
  assign wdata    = val_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Scoreboard bench for cam_init_sequencer: a table ROM and I2C slave model feed the DUT,
// and every issued transaction is popped against the expected queue.
module tb_cam_init_sequencer;

  localparam int unsigned AW   = 3;
  localparam logic [7:0]  DEV  = 8'h42;
  localparam int unsigned DLY  = 1024;
  localparam int unsigned STL  = 16;
  localparam int unsigned MAXR = 3;
  // Idle gaps of i2c_req between transactions: settle + fetch/latch (+ delay + fetch/latch)
  localparam int unsigned GAP_DLY2  = STL + 2 + 2 * DLY + 2;
  localparam int unsigned GAP_DLY0  = STL + 2 + 1 + 2;
  localparam int unsigned GAP_RETRY = STL;

  logic          clk = 1'b0;
  logic          res, start, i2c_req, i2c_done, i2c_nack, busy, done, error;
  logic [AW-1:0] tbl_addr, fail_idx;
  logic [15:0]   tbl_data;
  logic [7:0]    dev_addr, reg_addr, wdata;

  logic [15:0]   mem [1 << AW];
  logic [15:0]   exp_q [$];
  bit            nack_q [$];
  int unsigned   gap_q [$];
  int            tests = 0;
  int            fails = 0;
  int unsigned   cyc = 0;
  int unsigned   txn_cnt = 0;
  int unsigned   done_cnt = 0;
  bit            resp_en = 1'b1;
  int            spur_req = 0;

  cam_init_sequencer #(
    .DEV_ADDR(DEV), .TBL_AW(AW), .MAX_RETRY(MAXR), .DLY_UNIT(DLY), .SETTLE(STL)
  ) dut (
    .clk(clk), .res(res), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c_req(i2c_req), .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy), .done(done),
    .error(error), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Table ROM with one cycle of read latency, plus the I2C slave model
  initial begin : responder
    int          wait_n;
    bit          hold;
    logic [AW-1:0] addr_d1;
    int          spur_ack;
    i2c_done = 1'b0; i2c_nack = 1'b0; tbl_data = '0;
    wait_n = 0; hold = 1'b0; addr_d1 = '0; spur_ack = 0;
    forever begin
      @(negedge clk);
      tbl_data = mem[addr_d1];
      addr_d1  = tbl_addr;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (spur_req != spur_ack && !i2c_req) begin
        spur_ack = spur_req;
        i2c_done = 1'b1;
        i2c_nack = 1'b1;
      end else if (i2c_req && !hold && resp_en) begin
        wait_n++;
        if (wait_n >= 3) begin
          i2c_done = 1'b1;
          i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          hold = 1'b1;
          wait_n = 0;
        end
      end else if (!i2c_req) begin
        hold = 1'b0;
        wait_n = 0;
      end
    end
  end

  // Transaction monitor: scoreboard pop on each request, field stability while held
  initial begin : monitor
    logic        req_prev;
    logic [23:0] held;
    int unsigned fall_cyc;
    logic [15:0] e;
    req_prev = 1'b0; held = '0; fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (i2c_req === 1'b1 && !req_prev) begin
        txn_cnt++;
        gap_q.push_back(cyc - fall_cyc);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL txn_unexpected: got %h/%h/%h, expected no transaction", dev_addr, reg_addr, wdata);
        end else begin
          e = exp_q.pop_front();
          if ({dev_addr, reg_addr, wdata} !== {DEV, e}) begin
            fails++;
            $display("FAIL txn_fields: got %h/%h/%h, expected %h/%h/%h",
                     dev_addr, reg_addr, wdata, DEV, e[15:8], e[7:0]);
          end
        end
        held = {dev_addr, reg_addr, wdata};
      end else if (i2c_req === 1'b1) begin
        tests++;
        if ({dev_addr, reg_addr, wdata} !== held) begin
          fails++;
          $display("FAIL txn_stable: got %h, held %h", {dev_addr, reg_addr, wdata}, held);
        end
      end
      if (i2c_req !== 1'b1 && req_prev) fall_cyc = cyc;
      req_prev = (i2c_req === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n = 0;
    while (i2c_req !== lvl && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (i2c_req !== lvl) begin
      fails++;
      $display("FAIL %s_req_timeout: i2c_req=%b, expected %b", name, i2c_req, lvl);
    end
  endtask

  task automatic run_table(input string name);
    int n = 0;
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy_rise: got %b, expected 1", name, busy);
    end
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
    tick(2);
  endtask

  task automatic test_reset();
    res = 1'b0; start = 1'b0;
    tick(3);
    tests++;
    if ({i2c_req, busy, done, error} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: req/busy/done/error=%b%b%b%b, expected 0000", i2c_req, busy, done, error);
    end
    tests++;
    if ({tbl_addr, fail_idx} !== '0) begin
      fails++;
      $display("FAIL reset_idx: tbl_addr=%0d fail_idx=%0d, expected 0/0", tbl_addr, fail_idx);
    end
    tests++;
    if ({dev_addr, reg_addr, wdata} !== 24'h0) begin
      fails++;
      $display("FAIL reset_fields: got %h/%h/%h, expected 00/00/00", dev_addr, reg_addr, wdata);
    end
    res = 1'b1;
    tick(5);
    tests++;
    if ({i2c_req, busy, done, error, tbl_addr} !== '0) begin
      fails++;
      $display("FAIL reset_hold: req=%b busy=%b addr=%0d, expected idle", i2c_req, busy, tbl_addr);
    end
  endtask

  task automatic check_end(input string name, input int unsigned txn0, input int unsigned done0,
                           input int unsigned exp_txn, input int unsigned exp_done, input logic exp_err);
    tests++;
    if (txn_cnt - txn0 != exp_txn || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_count: %0d transactions (%0d expected left), expected %0d",
               name, txn_cnt - txn0, exp_q.size(), exp_txn);
    end
    tests++;
    if (done_cnt - done0 != exp_done) begin
      fails++;
      $display("FAIL %s_done: %0d done cycles, expected %0d", name, done_cnt - done0, exp_done);
    end
    tests++;
    if (error !== exp_err) begin
      fails++;
      $display("FAIL %s_error: got %b, expected %b", name, error, exp_err);
    end
  endtask

  task automatic test_delay_table();
    int unsigned t0 = txn_cnt, d0 = done_cnt;
    mem[0] = 16'h1280; mem[1] = 16'hF002; mem[2] = 16'h1101; mem[3] = 16'hFFFF;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    gap_q.delete();
    run_table("delay");
    check_end("delay", t0, d0, 2, 1, 1'b0);
    tests++;
    if (gap_q.size() != 2 || gap_q[1] != GAP_DLY2) begin
      fails++;
      $display("FAIL delay_gap: %0d gaps, last %0d, expected %0d",
               gap_q.size(), (gap_q.size() > 0) ? gap_q[gap_q.size()-1] : 0, GAP_DLY2);
    end
  endtask

  task automatic test_retry();
    int unsigned t0 = txn_cnt, d0 = done_cnt;
    mem[0] = 16'h3A04; mem[1] = 16'hFFFF;
    nack_q.push_back(1'b1); nack_q.push_back(1'b1);
    repeat (3) exp_q.push_back(16'h3A04);
    gap_q.delete();
    run_table("retry");
    check_end("retry", t0, d0, 3, 1, 1'b0);
    tests++;
    if (gap_q.size() != 3 || gap_q[1] != GAP_RETRY || gap_q[2] != GAP_RETRY) begin
      fails++;
      $display("FAIL retry_gap: %0d gaps, expected 3 with retry gaps of %0d", gap_q.size(), GAP_RETRY);
    end
  endtask

  task automatic test_nack_fail();
    int unsigned t0 = txn_cnt, d0 = done_cnt;
    for (int i = 0; i < 6; i++) mem[i] = {8'(8'h20 + i), 8'(8'hB0 + i)};
    mem[6] = 16'hFFFF; mem[7] = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      nack_q.push_back(1'b0);
      exp_q.push_back(mem[i]);
    end
    for (int i = 0; i <= MAXR; i++) begin
      nack_q.push_back(1'b1);
      exp_q.push_back(mem[5]);
    end
    run_table("nackfail");
    check_end("nackfail", t0, d0, 5 + MAXR + 1, 0, 1'b1);
    tests++;
    if (fail_idx !== AW'(5)) begin
      fails++;
      $display("FAIL nackfail_idx: got %0d, expected 5", fail_idx);
    end
  endtask

  task automatic test_wrap();
    int unsigned t0 = txn_cnt, d0 = done_cnt;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = {8'(8'h30 + i), 8'(8'hC0 + i)};
      exp_q.push_back(mem[i]);
    end
    pulse_start();
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL wrap_err_clear: got %b, expected 0", error);
    end
    while (busy !== 1'b0) @(negedge clk);
    tick(2);
    check_end("wrap", t0, d0, 1 << AW, 0, 1'b1);
    tests++;
    if (fail_idx !== AW'((1 << AW) - 1)) begin
      fails++;
      $display("FAIL wrap_idx: got %0d, expected %0d", fail_idx, (1 << AW) - 1);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0, d0;
    mem[0] = 16'h5C33; mem[1] = 16'hFFFF;
    exp_q.push_back(16'h5C33);
    resp_en = 1'b0;
    pulse_start();
    wait_req(1'b1, "rstmid");
    tick(3);
    res = 1'b0;
    tick(1);
    tests++;
    if ({i2c_req, busy} !== 2'b00 || tbl_addr !== '0) begin
      fails++;
      $display("FAIL rstmid_abort: req=%b busy=%b addr=%0d, expected 0/0/0", i2c_req, busy, tbl_addr);
    end
    res = 1'b1;
    resp_en = 1'b1;
    tick(2);
    t0 = txn_cnt; d0 = done_cnt;
    exp_q.push_back(16'h5C33);
    run_table("rstmid");
    check_end("rstmid", t0, d0, 1, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int unsigned t0 = txn_cnt, d0 = done_cnt;
    mem[0] = 16'h4011; mem[1] = 16'hF000; mem[2] = 16'h4122; mem[3] = 16'hFFFF;
    exp_q.push_back(16'h4011); exp_q.push_back(16'h4122);
    gap_q.delete();
    pulse_start();
    tick(2);
    pulse_start();
    wait_req(1'b1, "b2b");
    wait_req(1'b0, "b2b");
    spur_req++;
    tick(3);
    pulse_start();
    while (busy !== 1'b0) @(negedge clk);
    tick(2);
    check_end("b2b", t0, d0, 2, 1, 1'b0);
    tests++;
    if (gap_q.size() != 2 || gap_q[1] != GAP_DLY0) begin
      fails++;
      $display("FAIL b2b_gap: %0d gaps, last %0d, expected %0d",
               gap_q.size(), (gap_q.size() > 0) ? gap_q[gap_q.size()-1] : 0, GAP_DLY0);
    end
    tick(30);
    tests++;
    if (busy !== 1'b0 || txn_cnt - t0 != 2) begin
      fails++;
      $display("FAIL b2b_quiet: busy=%b txns=%0d, expected 0/2", busy, txn_cnt - t0);
    end
  endtask

  initial begin
    res = 1'b0;
    start = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hFFFF;
    test_reset();
    test_delay_table();
    test_retry();
    test_nack_fail();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
